// File: rtl/connect4_pkg.sv
// Shared definitions for the Connect4 move controller: FSM encoding, game
// result codes, default board size and the row/column to cell-index mapping.
package connect4_pkg;

    localparam int DEFAULT_ROWS = 4;
    localparam int DEFAULT_COLS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VALIDATE,
        S_WRITE,
        S_CHECK,
        S_RESOLVE,
        S_OVER
    } fsm_state_t;

    typedef enum logic [1:0] {
        PLAYING = 2'b00,
        WIN_P1  = 2'b01,
        WIN_P2  = 2'b10,
        DRAW    = 2'b11
    } game_state_t;

    function automatic int cell_index(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/connect4_move_controller_column_height_tracker.sv
// Per-column fill counters; a column's height is the row the next piece
// dropped into it will land on.
module column_height_tracker
    import connect4_pkg::*;
#(
    parameter int ROWS   = DEFAULT_ROWS,
    parameter int COLS   = DEFAULT_COLS,
    parameter int HGT_W  = $clog2(ROWS + 1),
    parameter int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    inc,
    input  logic [CIDX_W-1:0]       inc_col,
    output logic [COLS*HGT_W-1:0]   heights,
    output logic [COLS-1:0]         full
);

    logic [HGT_W-1:0] height_q [COLS];

    // Saturate at ROWS so a stray increment can never wrap a full column to empty.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int c = 0; c < COLS; c++) begin
                height_q[c] <= '0;
            end
        end else if (inc && (height_q[inc_col] != HGT_W'(ROWS))) begin
            height_q[inc_col] <= height_q[inc_col] + 1'b1;
        end
    end

    always_comb begin
        heights = '0;
        full    = '0;
        for (int c = 0; c < COLS; c++) begin
            heights[c*HGT_W +: HGT_W] = height_q[c];
            full[c]                   = (height_q[c] == HGT_W'(ROWS));
        end
    end

endmodule

// File: rtl/connect4_move_controller.sv
// Sequences one Connect4 move at a time: validate column, drop piece, run the
// winner detector, then alternate turns or end the game. Owns board and turn.
module connect4_move_controller
    import connect4_pkg::*;
#(
    parameter int ROWS          = DEFAULT_ROWS,
    parameter int COLS          = DEFAULT_COLS,
    parameter int COL_W         = 4,
    parameter int CHECK_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          move_req,
    input  logic [COL_W-1:0]              col_sel,
    input  logic                          new_game,
    input  logic                          win_valid,
    input  logic                          win_found,
    output logic [ROWS*COLS-1:0]          board_occ,
    output logic [ROWS*COLS-1:0]          board_owner,
    output logic                          current_player,
    output logic                          check_start,
    output logic [$clog2(ROWS*COLS)-1:0]  last_cell,
    output logic                          move_reject,
    output logic                          busy,
    output logic [1:0]                    game_state
);

    localparam int CELLS  = ROWS * COLS;
    localparam int CELL_W = $clog2(CELLS);
    localparam int HGT_W  = $clog2(ROWS + 1);
    localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W  = $clog2(CELLS + 1);
    localparam int TMR_W  = $clog2(CHECK_TIMEOUT + 1);

    fsm_state_t         state_q, state_d;
    game_state_t        result_q, result_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [CELLS-1:0]   occ_q, occ_d;
    logic [CELLS-1:0]   owner_q, owner_d;
    logic [CELL_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               player_q, player_d;
    logic               start_q, start_d;
    logic               reject_q, reject_d;
    logic               busy_q, busy_d;
    logic               verdict_q, verdict_d;

    logic [COLS*HGT_W-1:0] heights;
    logic [COLS-1:0]       full;
    logic [CIDX_W-1:0]     col_idx;
    logic [HGT_W-1:0]      cur_height;
    logic [CELL_W-1:0]     wr_idx;
    logic                  col_illegal;
    logic                  clear_board;

    assign col_idx     = col_q[CIDX_W-1:0];
    assign cur_height  = heights[32'(col_idx)*HGT_W +: HGT_W];
    assign wr_idx      = CELL_W'(cell_index(int'(cur_height), int'(col_idx), COLS));
    assign col_illegal = (int'(col_q) >= COLS);
    assign clear_board = new_game && ((state_q == S_IDLE) || (state_q == S_OVER));

    column_height_tracker #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .HGT_W  (HGT_W),
        .CIDX_W (CIDX_W)
    ) u_heights (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_board),
        .inc     (state_q == S_WRITE),
        .inc_col (col_idx),
        .heights (heights),
        .full    (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            result_q  <= PLAYING;
            col_q     <= '0;
            occ_q     <= '0;
            owner_q   <= '0;
            last_q    <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            player_q  <= 1'b0;
            start_q   <= 1'b0;
            reject_q  <= 1'b0;
            busy_q    <= 1'b0;
            verdict_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            col_q     <= col_d;
            occ_q     <= occ_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            player_q  <= player_d;
            start_q   <= start_d;
            reject_q  <= reject_d;
            busy_q    <= busy_d;
            verdict_q <= verdict_d;
        end
    end

    // Every output is computed here as a next value so all of them leave a flop.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        col_d     = col_q;
        occ_d     = occ_q;
        owner_d   = owner_q;
        last_d    = last_q;
        count_d   = count_q;
        timer_d   = timer_q;
        player_d  = player_q;
        verdict_d = verdict_q;
        start_d   = 1'b0;
        reject_d  = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (new_game) begin
                    occ_d    = '0;
                    owner_d  = '0;
                    count_d  = '0;
                    player_d = 1'b0;
                    result_d = PLAYING;
                    state_d  = S_IDLE;
                end else if (move_req && (state_q == S_IDLE)) begin
                    col_d   = col_sel;
                    state_d = S_VALIDATE;
                end
            end
            S_VALIDATE: begin
                if (col_illegal || full[col_idx]) begin
                    reject_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                occ_d[wr_idx]   = 1'b1;
                owner_d[wr_idx] = player_q;
                last_d          = wr_idx;
                count_d         = count_q + 1'b1;
                timer_d         = '0;
                start_d         = 1'b1;
                state_d         = S_CHECK;
            end
            S_CHECK: begin
                // A silent detector is treated as "no win" so play cannot stall.
                if (win_valid) begin
                    verdict_d = win_found;
                    state_d   = S_RESOLVE;
                end else if (timer_q == TMR_W'(CHECK_TIMEOUT - 1)) begin
                    verdict_d = 1'b0;
                    state_d   = S_RESOLVE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESOLVE: begin
                if (verdict_q) begin
                    result_d = player_q ? WIN_P2 : WIN_P1;
                    state_d  = S_OVER;
                end else if (count_q == CNT_W'(CELLS)) begin
                    result_d = DRAW;
                    state_d  = S_OVER;
                end else begin
                    player_d = ~player_q;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_OVER);
    end

    assign board_occ      = occ_q;
    assign board_owner    = owner_q;
    assign current_player = player_q;
    assign check_start    = start_q;
    assign last_cell      = last_q;
    assign move_reject    = reject_q;
    assign busy           = busy_q;
    assign game_state     = result_q;

endmodule

// File: tb/tb_connect4_move_controller.sv
// Self-checking bench: directed scenarios plus random games, scored against a
// 2-D board model that follows the game rules directly.
module tb_connect4_move_controller;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int CELLS = ROWS * COLS;

    logic        clk = 1'b0;
    logic        reset;
    logic        move_req;
    logic [3:0]  col_sel;
    logic        new_game;
    logic        win_valid;
    logic        win_found;
    logic [15:0] board_occ;
    logic [15:0] board_owner;
    logic        current_player;
    logic        check_start;
    logic [3:0]  last_cell;
    logic        move_reject;
    logic        busy;
    logic [1:0]  game_state;

    int checkCount = 0;
    int errorCount = 0;

    // Model: -1 empty, otherwise owning player; row 0 is the bottom.
    int modelBoard [ROWS][COLS];
    int modelPlayer;
    int modelState;
    bit modelOver;

    always #5 clk = ~clk;

    connect4_move_controller dut (
        .clk            (clk),
        .reset          (reset),
        .move_req       (move_req),
        .col_sel        (col_sel),
        .new_game       (new_game),
        .win_valid      (win_valid),
        .win_found      (win_found),
        .board_occ      (board_occ),
        .board_owner    (board_owner),
        .current_player (current_player),
        .check_start    (check_start),
        .last_cell      (last_cell),
        .move_reject    (move_reject),
        .busy           (busy),
        .game_state     (game_state)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                modelBoard[r][c] = -1;
        modelPlayer = 0;
        modelState  = 0;
        modelOver   = 1'b0;
    endtask

    function automatic int colHeight(input int col);
        int h = 0;
        for (int r = 0; r < ROWS; r++)
            if (modelBoard[r][col] != -1) h++;
        return h;
    endfunction

    function automatic int moveCount();
        int n = 0;
        for (int c = 0; c < COLS; c++) n += colHeight(c);
        return n;
    endfunction

    function automatic logic [15:0] expOcc();
        logic [15:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (modelBoard[r][c] != -1) v[r*COLS + c] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] expOwner();
        logic [15:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (modelBoard[r][c] == 1) v[r*COLS + c] = 1'b1;
        return v;
    endfunction

    task automatic checkBoardState(input string tag);
        checkOutput({tag, "_occ"},    32'(board_occ),      32'(expOcc()));
        checkOutput({tag, "_owner"},  32'(board_owner),    32'(expOwner()));
        checkOutput({tag, "_player"}, 32'(current_player), modelPlayer);
        checkOutput({tag, "_state"},  32'(game_state),     modelState);
        checkOutput({tag, "_busy"},   32'(busy),           0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_occ"},    32'(board_occ),      0);
        checkOutput({tag, "_owner"},  32'(board_owner),    0);
        checkOutput({tag, "_player"}, 32'(current_player), 0);
        checkOutput({tag, "_start"},  32'(check_start),    0);
        checkOutput({tag, "_reject"}, 32'(move_reject),    0);
        checkOutput({tag, "_busy"},   32'(busy),           0);
        checkOutput({tag, "_last"},   32'(last_cell),      0);
        checkOutput({tag, "_state"},  32'(game_state),     0);
    endtask

    task automatic resetDut();
        reset = 1'b1; move_req = 1'b0; new_game = 1'b0; win_valid = 1'b0; win_found = 1'b0;
        tick();
        reset = 1'b0;
        clearModel();
        checkResetValues("reset");
    endtask

    task automatic newGame();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        clearModel();
        checkBoardState("new_game");
    endtask

    // One complete move request; delay = cycles after check_start before the verdict.
    task automatic applyStimulus(input int col, input bit silent, input int delay, input bit win, input bit poke);
        int  h;
        bit  legal;
        int  expTicks;
        int  ticks;
        col_sel  = 4'(col);
        move_req = 1'b1;
        tick();
        move_req = 1'b0;
        if (modelOver) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("over_busy", 32'(busy), 0);
                checkOutput("over_reject", 32'(move_reject), 0);
                tick();
            end
            checkBoardState("over_hold");
            return;
        end
        checkOutput("busy_n1", 32'(busy), 1);
        h     = (col < COLS) ? colHeight(col) : ROWS;
        legal = (col < COLS) && (h < ROWS);
        if (poke) begin
            move_req = 1'b1; new_game = 1'b1; col_sel = 4'((col + 1) % COLS);
        end
        tick();
        move_req = 1'b0; new_game = 1'b0;
        if (!legal) begin
            checkOutput("reject_n2", 32'(move_reject), 1);
            checkOutput("reject_busy", 32'(busy), 0);
            tick();
            checkOutput("reject_n3", 32'(move_reject), 0);
            checkBoardState("reject_hold");
            return;
        end
        checkOutput("reject_none", 32'(move_reject), 0);
        checkOutput("busy_write", 32'(busy), 1);
        modelBoard[h][col] = modelPlayer;
        if (poke) begin
            move_req = 1'b1; new_game = 1'b1; col_sel = 4'((col + 1) % COLS);
        end
        tick();
        move_req = 1'b0; new_game = 1'b0;
        checkOutput("check_start_n3", 32'(check_start), 1);
        checkOutput("occ_n3", 32'(board_occ), 32'(expOcc()));
        checkOutput("owner_n3", 32'(board_owner), 32'(expOwner()));
        checkOutput("last_cell", 32'(last_cell), h * COLS + col);
        expTicks = silent ? 16 : delay + 2;
        ticks    = -1;
        for (int c = 0; c < 40; c++) begin
            win_valid = !silent && (c == delay);
            win_found = win_valid ? win : 1'($urandom_range(0, 1));
            tick();
            if (c == 0) checkOutput("check_start_pulse", 32'(check_start), 0);
            if (!busy) begin
                ticks = c + 1;
                break;
            end
        end
        win_valid = 1'b0;
        win_found = 1'b0;
        checkOutput("check_latency", ticks, expTicks);
        if (!silent && win) begin
            modelState = (modelPlayer == 1) ? 2 : 1;
            modelOver  = 1'b1;
        end else if (moveCount() == CELLS) begin
            modelState = 3;
            modelOver  = 1'b1;
        end else begin
            modelPlayer ^= 1;
        end
        checkBoardState("after_move");
    endtask

    initial begin
        int winCols [7];
        int col;
        bit silent;
        bit win;
        bit poke;
        int delay;

        reset = 1'b1; move_req = 1'b0; col_sel = '0; new_game = 1'b0;
        win_valid = 1'b0; win_found = 1'b0;
        resetDut();

        $display("[TB] single move");
        applyStimulus(2, 1'b0, 0, 1'b0, 1'b0);

        $display("[TB] stacking and full column");
        resetDut();
        for (int i = 0; i < 5; i++) applyStimulus(1, 1'b0, i % 3, 1'b0, 1'b0);

        $display("[TB] illegal column");
        resetDut();
        applyStimulus(4, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(15, 1'b0, 0, 1'b0, 1'b0);

        $display("[TB] win and lockout");
        resetDut();
        winCols = '{0, 0, 1, 1, 2, 2, 3};
        for (int i = 0; i < 7; i++) applyStimulus(winCols[i], 1'b0, 1, (i == 6), 1'b0);
        applyStimulus(3, 1'b0, 0, 1'b0, 1'b0);
        newGame();

        $display("[TB] draw with a silent detector");
        for (int i = 0; i < CELLS; i++) applyStimulus(i % COLS, (i == 5), 0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 0, 1'b0, 1'b0);
        newGame();

        $display("[TB] new_game and move_req together");
        applyStimulus(0, 1'b0, 0, 1'b0, 1'b0);
        move_req = 1'b1; new_game = 1'b1; col_sel = 4'd2;
        tick();
        move_req = 1'b0; new_game = 1'b0;
        clearModel();
        checkOutput("ng_priority_busy", 32'(busy), 0);
        tick();
        checkBoardState("ng_priority");

        $display("[TB] move_req while busy");
        applyStimulus(3, 1'b0, 2, 1'b0, 1'b1);

        $display("[TB] reset during CHECK");
        col_sel = 4'd3; move_req = 1'b1;
        tick();
        move_req = 1'b0;
        tick();
        tick();
        checkOutput("mid_check_start", 32'(check_start), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clearModel();
        checkResetValues("reset_in_check");
        tick();
        checkBoardState("reset_in_check_hold");
        applyStimulus(3, 1'b0, 0, 1'b0, 1'b0);

        $display("[TB] random games");
        for (int g = 0; g < 8; g++) begin
            if (g % 2 == 0) resetDut();
            else newGame();
            for (int m = 0; m < 40; m++) begin
                col    = $urandom_range(0, 5);
                silent = ($urandom_range(0, 7) == 0);
                delay  = $urandom_range(0, 4);
                win    = ($urandom_range(0, 9) == 0) && (moveCount() >= 3);
                poke   = ($urandom_range(0, 3) == 0);
                applyStimulus(col, silent, delay, win, poke);
                if (modelOver) begin
                    applyStimulus(0, 1'b0, 0, 1'b0, 1'b0);
                    break;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
